// File: rtl/jpeg_mcu_block_sched.sv
// Interleaves Y/Cb/Cr Huffman code-word streams into JPEG MCU order behind one
// registered AXI4-Stream output stage. Optional grayscale mode: JPEG_SCHED_GRAY_EN.
module jpeg_mcu_block_sched #(
    parameter int Y_BLOCKS_PER_MCU = 1,
    parameter int MCU_CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [MCU_CNT_W-1:0] cfg_mcu_count,
`ifdef JPEG_SCHED_GRAY_EN
    input  logic                 cfg_gray,
`endif
    output logic                 busy,
    output logic                 done,
    input  logic [31:0]          s_y_tdata,
    input  logic                 s_y_tvalid,
    input  logic                 s_y_tlast,
    output logic                 s_y_tready,
    input  logic [31:0]          s_cb_tdata,
    input  logic                 s_cb_tvalid,
    input  logic                 s_cb_tlast,
    output logic                 s_cb_tready,
    input  logic [31:0]          s_cr_tdata,
    input  logic                 s_cr_tvalid,
    input  logic                 s_cr_tlast,
    output logic                 s_cr_tready,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tuser,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready
);
    localparam int YBLK_W = 3;
    localparam logic [YBLK_W-1:0] Y_LAST_BLK = YBLK_W'(Y_BLOCKS_PER_MCU - 1);

    typedef enum logic [2:0] {IDLE, SEL_Y, SEL_CB, SEL_CR, FLUSH} state_e;

    state_e               state_q, state_d;
    logic [MCU_CNT_W-1:0] mcu_left_q, mcu_left_d;
    logic [YBLK_W-1:0]    y_blk_q, y_blk_d;
    logic                 first_q, first_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [31:0]          tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 tuser_q, tuser_d;
    logic                 tlast_q, tlast_d;

    logic                 load;
    logic                 src_valid;
    logic                 src_last;
    logic [31:0]          src_data;
    logic                 hs;
    logic                 mcu_last;
    logic                 gray_mode;

`ifdef JPEG_SCHED_GRAY_EN
    logic gray_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            gray_q <= cfg_gray;
        end
    end
    assign gray_mode = gray_q;
`else
    assign gray_mode = 1'b0;
`endif

    // The output register can take a new word whenever it is empty or draining.
    assign load     = !tvalid_q || m_axis_tready;
    assign mcu_last = (mcu_left_q == MCU_CNT_W'(1));
    assign hs       = load && src_valid;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        s_y_tready  = 1'b0;
        s_cb_tready = 1'b0;
        s_cr_tready = 1'b0;
        src_valid   = 1'b0;
        src_last    = 1'b0;
        src_data    = '0;
        unique case (state_q)
            SEL_Y: begin
                s_y_tready = load;
                src_valid  = s_y_tvalid;
                src_last   = s_y_tlast;
                src_data   = s_y_tdata;
            end
            SEL_CB: begin
                s_cb_tready = load;
                src_valid   = s_cb_tvalid;
                src_last    = s_cb_tlast;
                src_data    = s_cb_tdata;
            end
            SEL_CR: begin
                s_cr_tready = load;
                src_valid   = s_cr_tvalid;
                src_last    = s_cr_tlast;
                src_data    = s_cr_tdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tuser_d    = tuser_q;
        tlast_d    = tlast_q;
        first_d    = first_q;
        state_d    = state_q;
        mcu_left_d = mcu_left_q;
        y_blk_d    = y_blk_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (hs) begin
            tdata_d  = src_data;
            tvalid_d = 1'b1;
            tuser_d  = first_q;
            first_d  = 1'b0;
            tlast_d  = src_last && mcu_last &&
                       (state_q == SEL_CR || (state_q == SEL_Y && gray_mode));
        end else if (load) begin
            tvalid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcu_left_d = cfg_mcu_count;
                    first_d    = 1'b1;
                    busy_d     = 1'b1;
                    y_blk_d    = '0;
                    state_d    = (cfg_mcu_count == '0) ? FLUSH : SEL_Y;
                end
            end
            SEL_Y: begin
                if (hs && src_last) begin
                    if (gray_mode) begin
                        // Grayscale MCU is a single Y block; the chroma states are skipped.
                        mcu_left_d = mcu_left_q - MCU_CNT_W'(1);
                        y_blk_d    = '0;
                        state_d    = mcu_last ? FLUSH : SEL_Y;
                    end else begin
                        y_blk_d = y_blk_q + YBLK_W'(1);
                        if (y_blk_q == Y_LAST_BLK) begin
                            state_d = SEL_CB;
                        end
                    end
                end
            end
            SEL_CB: begin
                if (hs && src_last) begin
                    state_d = SEL_CR;
                end
            end
            SEL_CR: begin
                if (hs && src_last) begin
                    mcu_left_d = mcu_left_q - MCU_CNT_W'(1);
                    y_blk_d    = '0;
                    state_d    = mcu_last ? FLUSH : SEL_Y;
                end
            end
            FLUSH: begin
                // Done only once the final word has left the output register.
                if (!tvalid_q || (m_axis_tready && tlast_q)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mcu_left_q <= '0;
            y_blk_q    <= '0;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tuser_q    <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcu_left_q <= mcu_left_d;
            y_blk_q    <= y_blk_d;
            first_q    <= first_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tuser_q    <= tuser_d;
            tlast_q    <= tlast_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_jpeg_mcu_block_sched.sv
// Scoreboard bench for jpeg_mcu_block_sched: one instance with 1 Y block/MCU, one
// with 4 Y blocks/MCU, sharing the source/sink models through a select.
module tb_jpeg_mcu_block_sched;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] cfg_mcu_count = '0;
`ifdef JPEG_SCHED_GRAY_EN
    logic         cfg_gray = 1'b0;
`endif
    logic [31:0]  y_data = '0, cb_data = '0, cr_data = '0;
    logic         y_valid = 1'b0, cb_valid = 1'b0, cr_valid = 1'b0;
    logic         y_last = 1'b0, cb_last = 1'b0, cr_last = 1'b0;
    logic         m_ready = 1'b1;
    bit           sel = 1'b0;

    logic busy_a, done_a, yr_a, cbr_a, crr_a, mv_a, mu_a, ml_a;
    logic busy_b, done_b, yr_b, cbr_b, crr_b, mv_b, mu_b, ml_b;
    logic [31:0] md_a, md_b;
    logic busy, done, yr, cbr, crr, m_valid, m_user, m_last;
    logic [31:0] m_data;

    assign busy    = sel ? busy_b : busy_a;
    assign done    = sel ? done_b : done_a;
    assign yr      = sel ? yr_b   : yr_a;
    assign cbr     = sel ? cbr_b  : cbr_a;
    assign crr     = sel ? crr_b  : crr_a;
    assign m_valid = sel ? mv_b   : mv_a;
    assign m_user  = sel ? mu_b   : mu_a;
    assign m_last  = sel ? ml_b   : ml_a;
    assign m_data  = sel ? md_b   : md_a;

    always #5 clk = ~clk;

    jpeg_mcu_block_sched #(.Y_BLOCKS_PER_MCU(1), .MCU_CNT_W(W)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start && !sel), .cfg_mcu_count(cfg_mcu_count),
`ifdef JPEG_SCHED_GRAY_EN
        .cfg_gray(cfg_gray),
`endif
        .busy(busy_a), .done(done_a),
        .s_y_tdata(y_data), .s_y_tvalid(y_valid && !sel), .s_y_tlast(y_last), .s_y_tready(yr_a),
        .s_cb_tdata(cb_data), .s_cb_tvalid(cb_valid && !sel), .s_cb_tlast(cb_last), .s_cb_tready(cbr_a),
        .s_cr_tdata(cr_data), .s_cr_tvalid(cr_valid && !sel), .s_cr_tlast(cr_last), .s_cr_tready(crr_a),
        .m_axis_tdata(md_a), .m_axis_tvalid(mv_a), .m_axis_tuser(mu_a), .m_axis_tlast(ml_a),
        .m_axis_tready(m_ready)
    );

    jpeg_mcu_block_sched #(.Y_BLOCKS_PER_MCU(4), .MCU_CNT_W(W)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start && sel), .cfg_mcu_count(cfg_mcu_count),
`ifdef JPEG_SCHED_GRAY_EN
        .cfg_gray(cfg_gray),
`endif
        .busy(busy_b), .done(done_b),
        .s_y_tdata(y_data), .s_y_tvalid(y_valid && sel), .s_y_tlast(y_last), .s_y_tready(yr_b),
        .s_cb_tdata(cb_data), .s_cb_tvalid(cb_valid && sel), .s_cb_tlast(cb_last), .s_cb_tready(cbr_b),
        .s_cr_tdata(cr_data), .s_cr_tvalid(cr_valid && sel), .s_cr_tlast(cr_last), .s_cr_tready(crr_b),
        .m_axis_tdata(md_b), .m_axis_tvalid(mv_b), .m_axis_tuser(mu_b), .m_axis_tlast(ml_b),
        .m_axis_tready(m_ready)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Source queues hold {tlast, tdata}; scoreboard holds {tuser, tlast, tdata}.
    logic [32:0] yq[$], cbq[$], crq[$];
    logic [33:0] exp_q[$];

    int  cyc = 0;
    bit  mon_en = 1'b0;
    bit  bp_mode = 1'b0;
    int  out_cnt = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
    int  busy_cyc = 0, valid_cyc = 0, ylast_cnt = 0;
    bit  cb_early = 1'b0, cbcr_seen = 1'b0, stall_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Source model: handshakes sampled mid-cycle, queues advanced just after the edge.
    initial begin
        bit hs_y, hs_cb, hs_cr;
        forever begin
            @(negedge clk);
            hs_y  = y_valid && yr;
            hs_cb = cb_valid && cbr;
            hs_cr = cr_valid && crr;
            @(posedge clk);
            #1;
            if (hs_y && yq.size() > 0) void'(yq.pop_front());
            if (hs_cb && cbq.size() > 0) void'(cbq.pop_front());
            if (hs_cr && crq.size() > 0) void'(crq.pop_front());
            y_valid  = yq.size() > 0;
            cb_valid = cbq.size() > 0;
            cr_valid = crq.size() > 0;
            {y_last, y_data}   = y_valid  ? yq[0]  : 33'd0;
            {cb_last, cb_data} = cb_valid ? cbq[0] : 33'd0;
            {cr_last, cr_data} = cr_valid ? crq[0] : 33'd0;
        end
    end

    // Sink ready: always 1, or the 1,0,0,1 pattern under backpressure.
    initial begin
        int rcyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) m_ready = (rcyc % 4 == 0) || (rcyc % 4 == 3);
            else         m_ready = 1'b1;
            rcyc++;
        end
    end

    // Output monitor and scoreboard compare.
    initial begin
        bit          prev_stall = 1'b0;
        logic [33:0] prev_word = '0;
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_stall) begin
                    check("hold_valid", 64'(m_valid), 64'd1);
                    check("hold_word", 64'({m_user, m_last, m_data}), 64'(prev_word));
                end
                if (m_valid && !m_ready) begin
                    stall_seen = 1'b1;
                    check("src_rdy_stall", 64'({yr, cbr, crr}), 64'd0);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_word", 64'({m_user, m_last, m_data}), 64'(e));
                    end
                    out_cnt++;
                    if (m_last) last_hs_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (busy) busy_cyc++;
                if (m_valid) valid_cyc++;
                if (y_valid && yr && y_last) ylast_cnt++;
                if (cbr && ylast_cnt < 4) cb_early = 1'b1;
                if (cbr || crr) cbcr_seen = 1'b1;
                prev_stall = m_valid && !m_ready;
                prev_word  = {m_user, m_last, m_data};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Pushes one frame's source words and the expected output sequence in MCU order.
    task automatic load_frame(input int mcus, input int ybpm, input int wpb, input bit gray);
        int nblk;
        int total;
        int n;
        nblk  = gray ? 1 : ybpm + 2;
        total = mcus * nblk * wpb;
        n     = 0;
        for (int m = 0; m < mcus; m++) begin
            for (int b = 0; b < nblk; b++) begin
                for (int w = 0; w < wpb; w++) begin
                    logic [31:0] word;
                    logic        lst;
                    int          s;
                    s    = (gray || b < ybpm) ? 0 : ((b == ybpm) ? 1 : 2);
                    word = {12'd0, 4'((m + w + b) % 16), 4'(s), 4'(m), 4'(b), 4'(w)};
                    lst  = (w == wpb - 1);
                    case (s)
                        0:       yq.push_back({lst, word});
                        1:       cbq.push_back({lst, word});
                        default: crq.push_back({lst, word});
                    endcase
                    exp_q.push_back({n == 0, n == total - 1, word});
                    n++;
                end
            end
        end
    endtask

    task automatic pulse_start(input int mcus, input bit gray);
        ylast_cnt = 0; cb_early = 1'b0; cbcr_seen = 1'b0;
        busy_cyc = 0; valid_cyc = 0; stall_seen = 1'b0;
        start = 1'b1;
        cfg_mcu_count = W'(mcus);
`ifdef JPEG_SCHED_GRAY_EN
        cfg_gray = gray;
`else
        if (gray) $display("gray frame requested without grayscale support");
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic run_frame(input int mcus, input int ybpm, input int wpb, input bit gray,
                             input bit poke);
        int done_base;
        int words;
        words = mcus * (gray ? 1 : ybpm + 2) * wpb;
        done_base = done_cnt;
        load_frame(mcus, ybpm, wpb, gray);
        pulse_start(mcus, gray);
        if (poke) begin
            repeat (4) @(posedge clk);
            #1;
            start = 1'b1;
            cfg_mcu_count = W'(7);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        for (int t = 0; t < 5000 && done_cnt == done_base; t++) @(posedge clk);
        check("done_seen", 64'(done_cnt - done_base), 64'd1);
        if (words > 0) check("done_latency", 64'(done_cyc - last_hs_cyc), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 64'(done_cnt - done_base), 64'd1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("busy_clear", 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 64'({busy, done, m_valid, m_user, m_last, yr, cbr, crr, m_data}), 64'd0);
        sel = 1'b1;
        #1;
        check("reset_b", 64'({busy, done, m_valid, m_user, m_last, yr, cbr, crr, m_data}), 64'd0);
        sel = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // 4:4:4, two MCUs, two words per block, free-flowing.
        sel = 1'b0;
        run_frame(2, 1, 2, 1'b0, 1'b0);

        // 4:2:0, one MCU, one word per block; chroma must wait for the 4th Y block.
        sel = 1'b1;
        run_frame(1, 4, 1, 1'b0, 1'b0);
        check("cb_before_4th_y", 64'(cb_early), 64'd0);

        // Backpressure with a stray start while busy.
        bp_mode = 1'b1;
        run_frame(2, 4, 3, 1'b0, 1'b1);
        check("stalls_seen", 64'(stall_seen), 64'd1);
        bp_mode = 1'b0;

        // Empty frame.
        sel = 1'b0;
        run_frame(0, 1, 1, 1'b0, 1'b0);
        check("zero_no_valid", 64'(valid_cyc), 64'd0);
        check("zero_busy_cycles", 64'(busy_cyc >= 1 && busy_cyc <= 2), 64'd1);

        // Reset after the third output word, then a fresh frame.
        load_frame(2, 1, 1, 1'b0);
        pulse_start(2, 1'b0);
        base = out_cnt;
        for (int t = 0; t < 200 && out_cnt - base < 3; t++) @(posedge clk);
        check("rst_reach_word3", 64'(out_cnt - base >= 3), 64'd1);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_async_outs",
              64'({busy, done, m_valid, m_user, m_last, yr, cbr, crr, m_data}), 64'd0);
        yq.delete();
        cbq.delete();
        crq.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        run_frame(1, 1, 2, 1'b0, 1'b0);

`ifdef JPEG_SCHED_GRAY_EN
        // Grayscale on the 4-Y instance: chroma sources hold words that must never be taken.
        sel = 1'b1;
        cbq.push_back({1'b1, 32'h0000_1234});
        crq.push_back({1'b1, 32'h0000_5678});
        run_frame(3, 4, 2, 1'b1, 1'b0);
        check("gray_no_chroma_ready", 64'(cbcr_seen), 64'd0);
        check("gray_chroma_untouched", 64'(cbq.size() + crq.size()), 64'd2);
        cbq.delete();
        crq.delete();
        cfg_gray = 1'b0;
        @(posedge clk);
        #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
